msrv32_mp_reg_file: RTL and testbench



---
 rtl/msrv32_mp_reg_file.sv | 124 ++++++++++++
 tb/tb_msrv32_mp_reg_file.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_mp_reg_file.sv
// Multi-port integer register file with x0 hardwired to zero, busy scoreboard and sequential clear engine.
// Optional same-cycle write-to-read bypass enabled by defining MSRV32_RF_BYPASS_EN.
module msrv32_mp_reg_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned NRP   = 2,
  parameter int unsigned NWP   = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                clr_req_in,
  output logic                ready_out,
  input  logic [NRP*AW-1:0]   rs_addr_in,
  output logic [NRP*XLEN-1:0] rs_out,
  output logic [NRP-1:0]      busy_out,
  input  logic [NWP-1:0]      wr_en_in,
  input  logic [NWP*AW-1:0]   wr_addr_in,
  input  logic [NWP*XLEN-1:0] wr_data_in,
  input  logic                busy_set_en_in,
  input  logic [AW-1:0]       busy_set_addr_in
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic             ready;
  logic [AW-1:0]    rd_addr;

  assign ready     = (state_q == ST_READY);
  assign ready_out = ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= AW'(1);
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, clear pointer and scoreboard; a set beats a same-cycle clear (newer producer).
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    case (state_q)
      ST_CLEAR: begin
        busy_d    = '0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(NREGS - 1)) begin
          state_d   = ST_READY;
          clr_ptr_d = AW'(1);
        end
      end
      ST_READY: begin
        for (int w = 0; w < NWP; w++) begin
          if (wr_en_in[w]) begin
            busy_d[wr_addr_in[w*AW +: AW]] = 1'b0;
          end
        end
        if (busy_set_en_in) begin
          busy_d[busy_set_addr_in] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (clr_req_in) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = AW'(1);
          busy_d    = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = AW'(1);
        busy_d    = '0;
      end
    endcase
  end

  // Storage carries no reset so it can map onto RAM; the clear engine zeroes it instead.
  always_ff @(posedge clk_in) begin
    if (state_q == ST_CLEAR) begin
      regs_q[clr_ptr_q] <= '0;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        if (wr_en_in[w] && (wr_addr_in[w*AW +: AW] != '0)) begin
          regs_q[wr_addr_in[w*AW +: AW]] <= wr_data_in[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read ports; x0 and the whole CLEAR phase read as zero.
  always_comb begin
    rs_out   = '0;
    busy_out = '0;
    rd_addr  = '0;
    for (int p = 0; p < NRP; p++) begin
      rd_addr = rs_addr_in[p*AW +: AW];
      if (ready && (rd_addr != '0)) begin
        rs_out[p*XLEN +: XLEN] = regs_q[rd_addr];
        busy_out[p]            = busy_q[rd_addr];
`ifdef MSRV32_RF_BYPASS_EN
        for (int w = 0; w < NWP; w++) begin
          if (wr_en_in[w] && (wr_addr_in[w*AW +: AW] == rd_addr)) begin
            rs_out[p*XLEN +: XLEN] = wr_data_in[w*XLEN +: XLEN];
            busy_out[p]            = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_msrv32_mp_reg_file.sv
// Scoreboard bench for msrv32_mp_reg_file: expected read data/busy queued at stimulus time, compared mid-cycle.
module tb_msrv32_mp_reg_file;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRP   = 2;
  localparam int unsigned NWP   = 2;
`ifdef MSRV32_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic                clr_req_in;
  logic                ready_out;
  logic [NRP*AW-1:0]   rs_addr_in;
  logic [NRP*XLEN-1:0] rs_out;
  logic [NRP-1:0]      busy_out;
  logic [NWP-1:0]      wr_en_in;
  logic [NWP*AW-1:0]   wr_addr_in;
  logic [NWP*XLEN-1:0] wr_data_in;
  logic                busy_set_en_in;
  logic [AW-1:0]       busy_set_addr_in;

  msrv32_mp_reg_file #(
    .XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clr_req_in(clr_req_in), .ready_out(ready_out),
    .rs_addr_in(rs_addr_in), .rs_out(rs_out), .busy_out(busy_out),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .busy_set_en_in(busy_set_en_in), .busy_set_addr_in(busy_set_addr_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          id;
    int          port;
    logic [31:0] rs;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   exp_id   = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input int port, input logic [31:0] rs, input logic busy);
    exp_t e;
    e.id   = exp_id;
    e.port = port;
    e.rs   = rs;
    e.busy = busy;
    sb_q.push_back(e);
  endtask

  // Compare every queued expectation against the outputs mid-cycle.
  task automatic sb_check();
    exp_t e;
    @(negedge clk_in);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("rs_id%0d_p%0d", e.id, e.port), rs_out[e.port*XLEN +: XLEN], e.rs);
      chk($sformatf("busy_id%0d_p%0d", e.id, e.port), 32'(busy_out[e.port]), 32'(e.busy));
    end
    exp_id++;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    wr_en_in       = '0;
    busy_set_en_in = 1'b0;
    clr_req_in     = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rs_addr_in = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    wr_en_in[port]              = 1'b1;
    wr_addr_in[port*AW +: AW]   = AW'(addr);
    wr_data_in[port*XLEN +: XLEN] = data;
  endtask

  task automatic bset(input int addr);
    busy_set_en_in   = 1'b1;
    busy_set_addr_in = AW'(addr);
  endtask

  // Count edges until ready_out rises; bounded so a stuck FSM still reaches the summary.
  task automatic wait_ready(input string tag, input int start);
    int n;
    n = start;
    while (!ready_out && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'd31);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    idle();
    rs_addr_in       = '0;
    wr_addr_in       = '0;
    wr_data_in       = '0;
    busy_set_addr_in = '0;
    step();
    step();
    chk("ready_in_reset", 32'(ready_out), 32'd0);
    rst_in = 1'b0;

    // Five idle clear cycles, then three cycles of ignored writes/busy-sets/clear requests to x2.
    for (int i = 0; i < 5; i++) step();
    wr(0, 2, 32'h1234_5678);
    wr(1, 2, 32'h8765_4321);
    bset(2);
    clr_req_in = 1'b1;
    set_rd(2, 1);
    expect_rd(0, 32'h0, 1'b0);
    expect_rd(1, 32'h0, 1'b0);
    sb_check();
    for (int i = 0; i < 3; i++) step();
    idle();
    wait_ready("clear_len_after_reset", 8);

    // Full sweep: everything reads zero and not busy.
    for (int a = 0; a < 32; a += 2) begin
      set_rd(a, a + 1);
      expect_rd(0, 32'h0, 1'b0);
      expect_rd(1, 32'h0, 1'b0);
      sb_check();
      step();
    end

    // Write x5 on port0, read it on port1 in the same cycle.
    wr(0, 5, 32'hDEAD_BEEF);
    set_rd(0, 5);
    expect_rd(0, 32'h0, 1'b0);
    expect_rd(1, BYP ? 32'hDEAD_BEEF : 32'h0, 1'b0);
    sb_check();
    step();
    idle();
    expect_rd(1, 32'hDEAD_BEEF, 1'b0);
    sb_check();
    step();

    // Same-address collision: highest port wins.
    wr(0, 7, 32'h1111_1111);
    wr(1, 7, 32'h2222_2222);
    set_rd(7, 5);
    expect_rd(0, BYP ? 32'h2222_2222 : 32'h0, 1'b0);
    expect_rd(1, 32'hDEAD_BEEF, 1'b0);
    sb_check();
    step();
    idle();
    expect_rd(0, 32'h2222_2222, 1'b0);
    sb_check();
    step();

    // Writes to x0 are dropped, including from the bypass path.
    wr(0, 0, 32'hFFFF_FFFF);
    wr(1, 0, 32'hFFFF_FFFF);
    set_rd(7, 0);
    expect_rd(1, 32'h0, 1'b0);
    sb_check();
    step();
    idle();
    expect_rd(0, 32'h2222_2222, 1'b0);
    expect_rd(1, 32'h0, 1'b0);
    sb_check();
    step();

    // Scoreboard: set x9, visible the cycle after.
    bset(9);
    set_rd(9, 7);
    expect_rd(0, 32'h0, 1'b0);
    sb_check();
    step();
    idle();
    expect_rd(0, 32'h0, 1'b1);
    expect_rd(1, 32'h2222_2222, 1'b0);
    sb_check();
    step();
    // Write and set of x9 together: set wins.
    wr(0, 9, 32'h0000_0099);
    bset(9);
    expect_rd(0, BYP ? 32'h0000_0099 : 32'h0, BYP ? 1'b0 : 1'b1);
    sb_check();
    step();
    idle();
    expect_rd(0, 32'h0000_0099, 1'b1);
    sb_check();
    step();
    // Lone write clears busy.
    wr(1, 9, 32'h0000_00AA);
    expect_rd(0, BYP ? 32'h0000_00AA : 32'h0000_0099, BYP ? 1'b0 : 1'b1);
    sb_check();
    step();
    idle();
    expect_rd(0, 32'h0000_00AA, 1'b0);
    sb_check();
    step();

    // Clear request: writes and busy-set in the request cycle are overwritten.
    wr(0, 3, 32'hA5A5_A5A5);
    step();
    idle();
    set_rd(3, 9);
    expect_rd(0, 32'hA5A5_A5A5, 1'b0);
    sb_check();
    clr_req_in = 1'b1;
    bset(10);
    wr(1, 11, 32'h0BAD_F00D);
    step();
    idle();
    chk("ready_fall_on_clr", 32'(ready_out), 32'd0);
    wr(0, 3, 32'h5555_5555);
    bset(3);
    step();
    idle();
    wait_ready("clear_len_after_req", 1);
    set_rd(3, 10);
    expect_rd(0, 32'h0, 1'b0);
    expect_rd(1, 32'h0, 1'b0);
    sb_check();
    step();
    set_rd(11, 9);
    expect_rd(0, 32'h0, 1'b0);
    expect_rd(1, 32'h0, 1'b0);
    sb_check();
    step();

    // Asynchronous reset from READY drops ready_out without a clock edge.
    #3 rst_in = 1'b1;
    #1 chk("ready_async_reset", 32'(ready_out), 32'd0);
    step();
    rst_in = 1'b0;
    wait_ready("clear_len_after_rst", 0);

    // Reset asserted ten cycles into a requested clear restarts the engine.
    wr(0, 12, 32'hCAFE_0012);
    step();
    idle();
    clr_req_in = 1'b1;
    step();
    idle();
    for (int i = 0; i < 9; i++) step();
    #2 rst_in = 1'b1;
    #1 chk("ready_mid_clear_reset", 32'(ready_out), 32'd0);
    step();
    rst_in = 1'b0;
    wait_ready("clear_len_restart", 0);
    set_rd(12, 7);
    expect_rd(0, 32'h0, 1'b0);
    expect_rd(1, 32'h0, 1'b0);
    sb_check();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
